sysreg_bus_arbiter: RTL

Two-master arbiter and sequencer for the single-ported system register bus (9-bit address, 8-bit write/read data, one-cycle read/write strobes, registered read data). Masters are the host command interface (m0) and the C64-side register window (m1). Each master issues req/ack transactions. The arbiter grants round-robin, generates the strobes, and waits the read latency. It returns read data and a one-cycle ack to the granted master.

---
 rtl/sysreg_bus_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/sysreg_bus_arbiter.sv
// Two-master round-robin arbiter and sequencer for the system register bus.
// Generates one-cycle read/write strobes and waits out the read latency.
module sysreg_bus_arbiter #(
   parameter int READ_LATENCY = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       m0_req,
   input  logic       m0_we,
   input  logic [8:0] m0_addr,
   input  logic [7:0] m0_wdata,
   output logic       m0_ack,
   output logic [7:0] m0_rdata,
   input  logic       m1_req,
   input  logic       m1_we,
   input  logic [8:0] m1_addr,
   input  logic [7:0] m1_wdata,
   output logic       m1_ack,
   output logic [7:0] m1_rdata,
   output logic [8:0] reg_a,
   output logic [7:0] reg_d,
   input  logic [7:0] reg_q,
   output logic       reg_read_strobe,
   output logic       reg_write_strobe
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t     state;
   state_t     next_state;
   logic       gnt;
   logic       last_grant;
   logic       we_q;
   logic [2:0] cnt;
   logic       any_req;
   logic       sel;
   logic       cnt_last;

   assign cnt_last = (cnt == 3'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state       = state;
      any_req          = m0_req | m1_req;
      sel              = 1'b0;
      reg_read_strobe  = 1'b0;
      reg_write_strobe = 1'b0;
      m0_ack           = 1'b0;
      m1_ack           = 1'b0;
      // On a tie the master that did not win last time gets the bus
      if (m0_req && m1_req) begin
         sel = ~last_grant;
      end else begin
         sel = m1_req;
      end
      unique case (state)
         IDLE: begin
            if (any_req) begin
               next_state = ISSUE;
            end
         end
         ISSUE: begin
            reg_read_strobe  = ~we_q;
            reg_write_strobe = we_q;
            next_state       = we_q ? DONE : WAIT;
         end
         WAIT: begin
            if (cnt_last) begin
               next_state = DONE;
            end
         end
         DONE: begin
            m0_ack     = ~gnt;
            m1_ack     = gnt;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gnt        <= 1'b0;
         last_grant <= 1'b1;
         we_q       <= 1'b0;
         reg_a      <= 9'd0;
         reg_d      <= 8'd0;
         cnt        <= 3'd0;
         m0_rdata   <= 8'd0;
         m1_rdata   <= 8'd0;
      end else begin
         unique case (state)
            IDLE: begin
               if (any_req) begin
                  gnt        <= sel;
                  last_grant <= sel;
                  we_q       <= sel ? m1_we : m0_we;
                  reg_a      <= sel ? m1_addr : m0_addr;
                  reg_d      <= sel ? m1_wdata : m0_wdata;
               end
            end
            ISSUE: begin
               cnt <= 3'(READ_LATENCY);
            end
            WAIT: begin
               cnt <= cnt - 3'd1;
               // Last wait cycle: reg_q now holds the addressed register
               if (cnt_last) begin
                  if (gnt) begin
                     m1_rdata <= reg_q;
                  end else begin
                     m0_rdata <= reg_q;
                  end
               end
            end
            DONE: begin
            end
            default: begin
            end
         endcase
      end
   end

endmodule
